// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit with HI/LO result registers.
// Multiply is a one-bit-per-cycle shift-add. Divide is one-bit-per-cycle
// restoring division on magnitudes. MTHI/MTLO write HI/LO directly.
// Optional feature macro MDU_SIGNED_EN: when defined, MULT and DIV operate on
// signed operands. When it is undefined they behave exactly like MULTU/DIVU.

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_acc_nxt;
    logic [WIDTH-1:0]   mul_shf_nxt;
    logic [2*WIDTH-1:0] mul_result;

    logic [WIDTH:0]     div_cur;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   div_acc_nxt;
    logic [WIDTH-1:0]   div_shf_nxt;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;

`ifdef MDU_SIGNED_EN
    logic neg_q, neg_d;
    logic rem_neg_q, rem_neg_d;
    logic signed_op;
    logic a_neg;
    logic b_neg;

    // Operand magnitudes and result signs for signed MULT/DIV
    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        mag_a     = a_neg ? (~a + 1'b1) : a;
        mag_b     = b_neg ? (~b + 1'b1) : b;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        if (state_q == IDLE && start) begin
            neg_d     = a_neg ^ b_neg;
            rem_neg_d = a_neg;
        end
    end

    // Sign registers captured alongside the operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end
`else
    // Unsigned-only build: operands pass through untouched
    always_comb begin
        mag_a = a;
        mag_b = b;
    end
`endif

    // One multiply step (acc:shf shifts right, adding opnd when the LSB is set)
    // and one restoring-divide step (acc is the partial remainder, shf shifts
    // the dividend out at the top and the quotient in at the bottom)
    always_comb begin
        mul_sum     = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_acc_nxt = mul_sum[WIDTH:1];
        mul_shf_nxt = {mul_sum[0], shf_q[WIDTH-1:1]};
        mul_result  = {mul_acc_nxt, mul_shf_nxt};

        div_cur     = {acc_q, shf_q[WIDTH-1]};
        div_ge      = div_cur >= {1'b0, opnd_q};
        div_diff    = div_cur[WIDTH-1:0] - opnd_q;
        div_acc_nxt = div_ge ? div_diff : div_cur[WIDTH-1:0];
        div_shf_nxt = {shf_q[WIDTH-2:0], div_ge};
        div_quo     = div_shf_nxt;
        div_rem     = div_acc_nxt;

`ifdef MDU_SIGNED_EN
        if (neg_q) begin
            mul_result = ~mul_result + 1'b1;
            div_quo    = ~div_quo + 1'b1;
        end
        if (rem_neg_q) begin
            div_rem = ~div_rem + 1'b1;
        end
`endif
    end

    // Control FSM: accept requests when idle, iterate, then commit to HI/LO
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        shf_d   = shf_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d = MUL;
                            cnt_d   = '0;
                            acc_d   = '0;
                            shf_d   = mag_a;
                            opnd_d  = mag_b;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = DIV;
                            cnt_d   = '0;
                            acc_d   = '0;
                            shf_d   = mag_a;
                            opnd_d  = mag_b;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d = mul_acc_nxt;
                shf_d = mul_shf_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hi_d    = mul_result[2*WIDTH-1:WIDTH];
                    lo_d    = mul_result[WIDTH-1:0];
                    done_d  = 1'b1;
                end
            end
            DIV: begin
                acc_d = div_acc_nxt;
                shf_d = div_shf_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    hi_d    = div_rem;
                    lo_d    = div_quo;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            shf_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            shf_q   <= shf_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of mult_div_unit.
// Expected values depend on whether MDU_SIGNED_EN is defined for the build.

module tb_mult_div_unit;

`ifdef MDU_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = s;
        op    = o;
        a     = av;
        b     = bv;
    endtask

    // Called at a falling edge; ends at the falling edge after the result edge
    task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int disturb_at);
        applyStimulus(1'b1, o, av, bv);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, o, $urandom, $urandom);
        checkOutput({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        checkOutput({tag, " done_after_accept"}, 32'(done), 32'd0);
        for (int k = 1; k < 32; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (disturb_at > 0 && k == disturb_at)
                applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7);
            else if (disturb_at > 0 && k == disturb_at + 1)
                applyStimulus(1'b0, OP_DIVU, $urandom, $urandom);
            checkOutput({tag, " busy_running"}, 32'(busy), 32'd1);
            checkOutput({tag, " done_running"}, 32'(done), 32'd0);
            checkOutput({tag, " hi_held"}, hi, model_hi);
            checkOutput({tag, " lo_held"}, lo, model_lo);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " busy_final"}, 32'(busy), 32'd0);
        checkOutput({tag, " done_final"}, 32'(done), 32'd1);
        checkOutput({tag, " hi"}, hi, exp_hi);
        checkOutput({tag, " lo"}, lo, exp_lo);
        model_hi = exp_hi;
        model_lo = exp_lo;
    endtask

    // Single-edge register move or ignored op while idle
    task automatic moveOp(input string tag, input logic [2:0] o, input logic [31:0] av);
        applyStimulus(1'b1, o, av, 32'h0);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, o, 32'h0, 32'h0);
        if (o == OP_MTHI) model_hi = av;
        if (o == OP_MTLO) model_lo = av;
        checkOutput({tag, " hi"}, hi, model_hi);
        checkOutput({tag, " lo"}, lo, model_lo);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
    endtask

    // Directed sequence: reset, moves, arithmetic vectors, overlap, mid-op reset
    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, OP_MULTU, 32'h0, 32'h0);
        #2;
        checkOutput("reset hi", hi, 32'h0);
        checkOutput("reset lo", lo, 32'h0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        moveOp("mthi", OP_MTHI, 32'h0000_1234);
        moveOp("mtlo", OP_MTLO, 32'hCAFE_F00D);
        moveOp("op110", 3'b110, 32'h5555_AAAA);
        moveOp("op111", 3'b111, 32'h1111_2222);

        runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        runOp("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5,
              SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0004, 32'hFFFF_FFF1, 0);
        runOp("mult_m1xm1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              SIGNED_EN ? 32'h0000_0000 : 32'hFFFF_FFFE, 32'h0000_0001, 0);
        runOp("mult_7xm2", OP_MULT, 32'd7, 32'hFFFF_FFFE,
              SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0006, 32'hFFFF_FFF2, 0);
        runOp("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
              SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0001,
              SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC, 0);
        runOp("div_m7dm2", OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
              SIGNED_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFF9,
              SIGNED_EN ? 32'h0000_0003 : 32'h0000_0000, 0);
        runOp("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
              SIGNED_EN ? 32'h0000_0001 : 32'h0000_0007,
              SIGNED_EN ? 32'hFFFF_FFFD : 32'h0000_0000, 0);
        runOp("divu_100d0", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 0);
        runOp("div_m7d0", OP_DIV, 32'hFFFF_FFF9, 32'd0,
              32'hFFFF_FFF9, SIGNED_EN ? 32'h0000_0001 : 32'hFFFF_FFFF, 0);
        runOp("div_min_dm1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              SIGNED_EN ? 32'h0000_0000 : 32'h8000_0000,
              SIGNED_EN ? 32'h8000_0000 : 32'h0000_0000, 0);
        runOp("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 0);
        runOp("multu_3x4_overlap", OP_MULTU, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 5);

        @(posedge clk);
        @(negedge clk);
        checkOutput("idle done_cleared", 32'(done), 32'd0);
        checkOutput("idle busy", 32'(busy), 32'd0);

        applyStimulus(1'b1, OP_DIVU, 32'd1000, 32'd3);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, OP_DIVU, 32'h0, 32'h0);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("midop busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        model_hi = 32'h0;
        model_lo = 32'h0;
        checkOutput("midop_reset busy", 32'(busy), 32'd0);
        checkOutput("midop_reset done", 32'(done), 32'd0);
        checkOutput("midop_reset hi", hi, 32'h0);
        checkOutput("midop_reset lo", lo, 32'h0);
        @(negedge clk);
        checkOutput("midop_reset done_held", 32'(done), 32'd0);
        rst = 1'b0;
        runOp("multu_2x3_after_reset", OP_MULTU, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006, 0);

        @(posedge clk);
        @(negedge clk);
        checkOutput("end done_cleared", 32'(done), 32'd0);
        checkOutput("end hi_held", hi, 32'h0);
        checkOutput("end lo_held", lo, 32'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width; all values in this document use WIDTH=32.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request; sampled on a rising clk edge.
REQ-005 The block SHALL have port op, input, 3 bits: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are ignored.
REQ-006 The block SHALL have port a, input, WIDTH bits: operand A (register-file busA); dividend for DIV/DIVU; source data for MTHI/MTLO.
REQ-007 The block SHALL have port b, input, WIDTH bits: operand B (register-file busB); divisor for DIV/DIVU.
REQ-008 The block SHALL have port hi, output, WIDTH bits: HI register; high product or remainder.
REQ-009 The block SHALL have port lo, output, WIDTH bits: LO register; low product or quotient.
REQ-010 The block SHALL have port busy, output, 1 bit: an iterative operation is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when hi/lo receive an iterative result.

Function
REQ-012 The block SHALL implement states IDLE, MUL, DIV; IDLE->MUL on accepted MULT/MULTU; IDLE->DIV on accepted DIV/DIVU; MUL/DIV->IDLE after the 32nd iteration.
REQ-013 A start with a valid op SHALL be accepted only when busy=0; start while busy=1 SHALL be ignored, with no effect on state, hi, lo or the operation in progress.
REQ-014 On accepting an iterative op, the block SHALL latch a and b; changes to a and b afterwards SHALL NOT affect the result.
REQ-015 After accepting an iterative op at edge N, busy SHALL be 1 after edges N..N+31 and 0 after edge N+32.
REQ-016 At edge N+32, the block SHALL load hi/lo and assert done for exactly one cycle; latency is 32 cycles.
REQ-017 A new start SHALL be accepted on the edge where done is high.
REQ-018 Multiply SHALL be a one-bit-per-cycle shift-add producing the full 64-bit product {hi,lo}.
REQ-019 Divide SHALL be one-bit-per-cycle restoring division on magnitudes, giving quotient in lo and remainder in hi.
REQ-020 For a signed divide, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of a.
REQ-021 For a signed multiply, the product SHALL be negated when the operand signs differ.
REQ-022 Divide by zero SHALL NOT trap and SHALL set hi=a; lo SHALL be 0xFFFFFFFF, except for signed DIV with a<0, where lo SHALL be 0x00000001.
REQ-023 Signed DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-024 MTHI/MTLO accepted while idle SHALL write a into hi (MTHI) or lo (MTLO) at the same edge, leave the other register unchanged, leave busy low and leave done low.
REQ-025 hi and lo SHALL hold their values at all times other than REQ-016, REQ-024 and reset; they SHALL NOT expose partial results during an operation.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, hi=0, lo=0, busy=0, done=0 and clear the iteration counter and internal operand/accumulator registers.
REQ-027 Reset asserted mid-operation SHALL abandon the operation with no done pulse; the first rising edge with rst=0 SHALL accept a new start.

Configuration
REQ-028 With macro MDU_SIGNED_EN defined, MULT and DIV SHALL perform signed operations per REQ-020, REQ-021, REQ-022 and REQ-023.
REQ-029 Without MDU_SIGNED_EN, MULT and DIV SHALL behave identically to MULTU and DIVU, and no sign-correction logic SHALL be present.

Verification
REQ-030 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 32 cycles; done pulse at edge N+32; hi=0xFFFFFFFE lo=0x00000001.
REQ-031 MULT a=0xFFFFFFFD b=5 -> with MDU_SIGNED_EN: hi=0xFFFFFFFF lo=0xFFFFFFF1; without it: hi=0x00000004 lo=0xFFFFFFF1.
REQ-032 DIV a=0xFFFFFFF9 (-7) b=2 (MDU_SIGNED_EN) -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=0x00000064.
REQ-033 MULTU 3*4 started, DIVU start at cycle 5 -> second start ignored, hi=0 lo=12 at N+32; a change in a/b during the operation does not affect the result.
REQ-034 DIVU started, rst pulsed at cycle 10 -> busy=0 hi=0 lo=0 immediately, no done pulse; next MULTU 2*3 -> lo=6 after 32 cycles.
REQ-035 Idle MTHI a=0x00001234 then MTLO a=0xCAFEF00D -> hi=0x00001234 after first edge, lo=0xCAFEF00D after second; busy and done stay 0 throughout.
